// File: rtl/img_pkg.sv
// Shared definitions for the filtered-frame read path.
// Holds the default image geometry, the streamer FSM state encoding and the
// layout of one output pixel beat.
package img_pkg;

  localparam int unsigned DEF_IMG_W = 256;
  localparam int unsigned DEF_IMG_H = 256;
  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned DEF_AW    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_PIX_W-1:0] data;
    logic                 sof;
    logic                 eol;
    logic                 eof;
  } pix_beat_t;

endpackage

// File: rtl/pix_fifo2.sv
// Two-entry synchronous FIFO used as the skid buffer in front of the
// output stream. Push and pop in the same cycle are allowed while non-empty.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write push_data
//   push_data   entry to store
//   pop         discard the head entry (only while count != 0)
//   head        oldest entry (held stable until popped)
//   count       number of stored entries, 0..2
module pix_fifo2 #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_streamer.sv
// Drains one completed frame from the filtered-frame RAM in raster order and
// presents it as a valid/ready pixel stream with sof/eol/eof flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             stream one frame (sampled only when idle)
//   rd_en, rd_addr    RAM read strobe and address (y*IMG_W + x)
//   rd_data           RAM data, valid the cycle after rd_en
//   m_valid, m_ready  output handshake
//   m_data            pixel value
//   m_sof/m_eol/m_eof first pixel / last pixel of line / last pixel of frame
//   busy              frame in progress
//   done              one-cycle pulse after the eof beat is accepted
module frame_streamer
  import img_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H,
  parameter int unsigned PIX_W = DEF_PIX_W,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  input  logic [PIX_W-1:0] rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_eof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned BW = PIX_W + 3;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [AW-1:0] A_LAST = AW'(IMG_W * IMG_H - 1);

  state_t          state, state_nxt;
  logic [XW-1:0]   x_rd;
  logic [YW-1:0]   y_rd;
  logic            clear_rd;
  logic            pend;
  logic [2:0]      pend_flags;
  logic [BW-1:0]   head;
  logic [1:0]      count;
  logic            pop;
  logic [2:0]      level;

  pix_fifo2 #(.W(BW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data ({rd_data, pend_flags}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = head[BW-1:3];
  assign m_sof   = m_valid & head[2];
  assign m_eol   = m_valid & head[1];
  assign m_eof   = m_valid & head[0];
  assign busy    = (state != IDLE);

  // Slots committed after this edge: buffered + in flight - leaving now.
  // Keeping this below 2 guarantees the read landing next cycle has room.
  assign level = {1'b0, count} + {2'b00, pend} - {2'b00, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    clear_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
          clear_rd  = 1'b1;
        end
      end
      ISSUE: begin
        rd_en = (level < 3'd2);
        if ((level < 3'd2) && (rd_addr == A_LAST)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && m_eof) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      x_rd    <= '0;
      y_rd    <= '0;
    end else if (clear_rd) begin
      rd_addr <= '0;
      x_rd    <= '0;
      y_rd    <= '0;
    end else if (rd_en) begin
      rd_addr <= rd_addr + AW'(1);
      if (x_rd == X_LAST) begin
        x_rd <= '0;
        y_rd <= y_rd + YW'(1);
      end else begin
        x_rd <= x_rd + XW'(1);
      end
    end
  end

  // Flags ride alongside the RAM latency so they land in the FIFO with data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= 1'b0;
      pend_flags <= '0;
      done       <= 1'b0;
    end else begin
      pend       <= rd_en;
      pend_flags <= {(x_rd == '0) && (y_rd == '0),
                     (x_rd == X_LAST),
                     (x_rd == X_LAST) && (y_rd == Y_LAST)};
      done       <= (state == DRAIN) && pop && m_eof;
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4x3 instance
  logic        s_start = 1'b0, s_ready = 1'b0;
  logic        s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
  logic [15:0] s_rd_addr;
  logic [7:0]  s_rd_data = 8'd0, s_data;

  // default 256x256 instance
  logic        l_start = 1'b0, l_ready = 1'b0;
  logic        l_rd_en, l_valid, l_sof, l_eol, l_eof, l_busy, l_done;
  logic [15:0] l_rd_addr;
  logic [7:0]  l_rd_data = 8'd0, l_data;

  frame_streamer #(.IMG_W(4), .IMG_H(3), .PIX_W(8), .AW(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .m_valid(s_valid), .m_ready(s_ready), .m_data(s_data),
    .m_sof(s_sof), .m_eol(s_eol), .m_eof(s_eof), .busy(s_busy), .done(s_done)
  );

  frame_streamer dut_l (
    .clk(clk), .rst_n(rst_n), .start(l_start), .rd_en(l_rd_en), .rd_addr(l_rd_addr),
    .rd_data(l_rd_data), .m_valid(l_valid), .m_ready(l_ready), .m_data(l_data),
    .m_sof(l_sof), .m_eol(l_eol), .m_eof(l_eof), .busy(l_busy), .done(l_done)
  );

  // RAMs preloaded with value = address (low byte)
  always @(posedge clk) begin
    if (s_rd_en) s_rd_data <= s_rd_addr[7:0];
    if (l_rd_en) l_rd_data <= l_rd_addr[7:0];
  end

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  int         bq_data[$];
  logic [2:0] bq_flags[$];
  int         bq_edge[$];
  int         rq[$];
  int         dq[$];
  int         stab_err = 0;
  int         max_occ = 0;
  logic       stalled_prev = 1'b0;
  logic [10:0] hold = '0;

  int l_beats = 0, l_bad = 0, l_reads = 0, l_last_addr = -1;
  int l_eof_edge = 0, l_done_edge = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst_n && stalled_prev && (s_valid !== 1'b1 || {s_data, s_sof, s_eol, s_eof} !== hold))
      stab_err++;
    stalled_prev = rst_n && s_valid && !s_ready;
    hold = {s_data, s_sof, s_eol, s_eof};
    if (s_rd_en) rq.push_back(int'(s_rd_addr));
    if (s_valid && s_ready) begin
      bq_data.push_back(int'(s_data));
      bq_flags.push_back({s_sof, s_eol, s_eof});
      bq_edge.push_back(edge_cnt);
    end
    if (s_done) dq.push_back(edge_cnt);
    if (rq.size() - bq_data.size() > max_occ) max_occ = rq.size() - bq_data.size();

    if (l_rd_en) begin
      l_reads++;
      l_last_addr = int'(l_rd_addr);
    end
    if (l_valid && l_ready) begin
      if (l_data !== l_beats[7:0] || l_sof !== (l_beats == 0) ||
          l_eol !== ((l_beats % 256) == 255) || l_eof !== (l_beats == 65535))
        l_bad++;
      if (l_eof) l_eof_edge = edge_cnt;
      l_beats++;
    end
    if (l_done) l_done_edge = edge_cnt;
  end

  function automatic logic [2:0] exp_fl(input int i);
    return {i == 0, (i % 4) == 3, i == 11};
  endfunction

  task automatic clear_logs();
    bq_data.delete(); bq_flags.delete(); bq_edge.delete();
    rq.delete(); dq.delete();
    stab_err = 0; max_occ = 0; stalled_prev = 1'b0;
  endtask

  task automatic wait_frame(input int budget, input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rand_ready) s_ready = 1'($urandom_range(0, 1));
      if (dq.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
    s_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done}); end
    checks++; if (s_rd_addr !== 16'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", s_rd_addr); end
    checks++; if (s_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", s_data); end
    checks++; if ({l_rd_en, l_valid, l_busy, l_done} !== 4'b0) begin
      errors++; $display("FAIL reset_large: got %b expected 0000", {l_rd_en, l_valid, l_busy, l_done}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input bit check_timing, input int n);
    checks++; if (bq_data.size() !== 12) begin
      errors++; $display("FAIL %s_count: got %0d beats expected 12", tag, bq_data.size()); end
    for (int i = 0; i < 12 && i < bq_data.size(); i++) begin
      checks++; if (bq_data[i] !== i || bq_flags[i] !== exp_fl(i)) begin
        errors++; $display("FAIL %s_beat%0d: got data %0d flags %b expected data %0d flags %b",
                           tag, i, bq_data[i], bq_flags[i], i, exp_fl(i)); end
      if (check_timing) begin
        checks++; if (bq_edge[i] !== n + 3 + i) begin
          errors++; $display("FAIL %s_edge%0d: got %0d expected %0d", tag, i, bq_edge[i], n + 3 + i); end
      end
    end
    checks++; if (rq.size() !== 12) begin
      errors++; $display("FAIL %s_reads: got %0d expected 12", tag, rq.size()); end
    for (int i = 0; i < 12 && i < rq.size(); i++) begin
      checks++; if (rq[i] !== i) begin
        errors++; $display("FAIL %s_addr%0d: got %0d expected %0d", tag, i, rq[i], i); end
    end
    checks++; if (dq.size() !== 1) begin
      errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, dq.size()); end
    checks++; if (max_occ > 2) begin
      errors++; $display("FAIL %s_occupancy: got %0d expected <= 2", tag, max_occ); end
    checks++; if (s_busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy_end: got %b expected 0", tag, s_busy); end
  endtask

  task automatic test_full_speed();
    int n; bit ok;
    clear_logs();
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = edge_cnt;
    checks++; if (s_rd_en !== 1'b1 || s_rd_addr !== 16'd0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL fs_first_read: got rd_en %b addr %0d busy %b expected 1 0 1", s_rd_en, s_rd_addr, s_busy); end
    wait_frame(60, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fs_timeout: got no done expected done"); end
    check_frame("fs", 1'b1, n);
    checks++; if (dq.size() > 0 && dq[0] !== n + 15) begin
      errors++; $display("FAIL fs_done_edge: got %0d expected %0d", dq[0], n + 15); end
  endtask

  task automatic test_backpressure();
    int n; bit ok;
    clear_logs();
    s_ready = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = edge_cnt;
    wait_frame(300, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
    check_frame("bp", 1'b0, n);
    checks++; if (stab_err !== 0) begin
      errors++; $display("FAIL bp_stable: got %0d stall violations expected 0", stab_err); end
  endtask

  task automatic test_stall_start();
    bit ok;
    clear_logs();
    s_ready = 1'b0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rq.size() !== 2) begin
      errors++; $display("FAIL stall_reads: got %0d expected 2", rq.size()); end
    checks++; if (rq.size() == 2 && (rq[0] !== 0 || rq[1] !== 1)) begin
      errors++; $display("FAIL stall_addrs: got %0d,%0d expected 0,1", rq[0], rq[1]); end
    checks++; if (s_valid !== 1'b1 || s_data !== 8'd0 || s_sof !== 1'b1) begin
      errors++; $display("FAIL stall_hold: got valid %b data %0d sof %b expected 1 0 1", s_valid, s_data, s_sof); end
    s_ready = 1'b1;
    wait_frame(60, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
    check_frame("stall", 1'b0, 0);
    checks++; if (stab_err !== 0) begin
      errors++; $display("FAIL stall_stable: got %0d stall violations expected 0", stab_err); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_logs();
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 50 && bq_data.size() < 5; i++) @(negedge clk);
    checks++; if (bq_data.size() !== 5) begin
      errors++; $display("FAIL busy_reach5: got %0d beats expected 5", bq_data.size()); end
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_frame(60, 1'b0, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: got no done expected done"); end
    check_frame("busy", 1'b0, 0);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    clear_logs();
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 50 && bq_data.size() < 6; i++) @(negedge clk);
    checks++; if (bq_data.size() !== 6) begin
      errors++; $display("FAIL rst_reach6: got %0d beats expected 6", bq_data.size()); end
    rst_n = 1'b0;
    #1;
    checks++; if ({s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done} !== 7'b0 ||
                  s_rd_addr !== 16'd0 || s_data !== 8'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got ctrl %b addr %0d data %0d expected 0 0 0",
                         {s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done}, s_rd_addr, s_data); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dq.size() !== 0 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_quiet: got done %0d busy %b valid %b expected 0 0 0", dq.size(), s_busy, s_valid); end
    clear_logs();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_frame(60, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_restart_timeout: got no done expected done"); end
    check_frame("restart", 1'b0, 0);
  endtask

  task automatic test_full_frame();
    int n; bit ok;
    l_ready = 1'b1;
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    n = edge_cnt;
    ok = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      if (l_done_edge != 0) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL big_timeout: got no done expected done"); end
    checks++; if (l_beats !== 65536) begin errors++; $display("FAIL big_beats: got %0d expected 65536", l_beats); end
    checks++; if (l_reads !== 65536) begin errors++; $display("FAIL big_reads: got %0d expected 65536", l_reads); end
    checks++; if (l_bad !== 0) begin errors++; $display("FAIL big_content: got %0d bad beats expected 0", l_bad); end
    checks++; if (l_last_addr !== 65535) begin errors++; $display("FAIL big_last_addr: got %0d expected 65535", l_last_addr); end
    checks++; if (l_eof_edge !== n + 65538) begin errors++; $display("FAIL big_eof_edge: got %0d expected %0d", l_eof_edge, n + 65538); end
    checks++; if (l_done_edge !== n + 65539) begin errors++; $display("FAIL big_done_edge: got %0d expected %0d", l_done_edge, n + 65539); end
    checks++; if (l_busy !== 1'b0) begin errors++; $display("FAIL big_busy_end: got %b expected 0", l_busy); end
  endtask

  initial begin
    test_reset();
    test_full_speed();
    test_backpressure();
    test_stall_start();
    test_start_while_busy();
    test_reset_mid_frame();
    test_full_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
# frame_streamer

Reads the filtered image out of the 256x256 filtered-frame RAM in raster order and presents it as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame flags. It is the read side of the filtered-frame memory: the filter core writes one pixel per cycle into the RAM, and this block drains a completed frame to the display/UART/DMA sink. It absorbs downstream backpressure without dropping or duplicating pixels.

## Interface
- IMG_W, 256, pixels per line
- IMG_H, 256, lines per frame
- PIX_W, 8, pixel width in bits
- AW, 16, RAM address width; must satisfy 2^AW >= IMG_W*IMG_H
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request to stream one frame; sampled only in IDLE
- rd_en  out  1  RAM read strobe
- rd_addr  out  AW  RAM address, y*IMG_W + x
- rd_data  in  PIX_W  RAM read data, valid the cycle after rd_en (1-cycle synchronous RAM)
- m_valid  out  1  output pixel valid
- m_ready  in  1  sink accepts pixel
- m_data  out  PIX_W  pixel value
- m_sof  out  1  beat is pixel (0,0)
- m_eol  out  1  beat has x = IMG_W-1
- m_eof  out  1  beat is pixel (IMG_W-1, IMG_H-1)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last beat accepted

## Operation
- Reset values: rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_sof=m_eol=m_eof=0, busy=0, done=0; FSM in IDLE; all counters 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: start=1 -> ISSUE, busy=1, read counters cleared.
  - ISSUE: issue reads; after the read of address IMG_W*IMG_H-1 -> DRAIN.
  - DRAIN: no reads; when the m_eof beat handshakes -> IDLE, done=1 for one cycle, busy=0.
- start while busy is ignored (no queuing).
- Read issue rule: rd_en=1 iff state=ISSUE and (buffer occupancy + reads in flight - pop this cycle) < 2. rd_addr increments by 1 after each issued read; x_rd wraps IMG_W-1 -> 0 and increments y_rd.
- Flags computed at issue from x_rd/y_rd, delayed one cycle alongside the RAM latency, and stored with rd_data.
- Output buffer: 2-entry FIFO of {data, sof, eol, eof}; pushed the cycle after rd_en; popped on m_valid & m_ready. Guaranteed never to overflow by the issue rule.
- AXI-style rules: once m_valid=1, m_data and flags stay stable until m_ready=1; m_valid never depends combinationally on m_ready.
- Exactly IMG_W*IMG_H beats per frame; every address read exactly once.
- Reset mid-frame: everything returns to reset values immediately; an in-flight read's data is discarded; no done pulse.

## Timing
- start high at edge n -> rd_en=1, rd_addr=0 during cycle n+1; rd_data valid cycle n+2; m_valid=1 with pixel 0 and m_sof=1 in cycle n+3.
- With m_ready held 1: one beat per cycle, no bubbles; last beat in cycle n+2+IMG_W*IMG_H; done in the following cycle.
- m_ready deasserted: at most 2 further reads complete; rd_en stops within one cycle; throughput resumes one cycle after m_ready returns.
- done asserts the cycle after the m_eof handshake; start may be accepted in that same cycle (FSM already IDLE).

## Structure
- Shared package img_pkg: IMG_W, IMG_H, PIX_W, AW defaults, FSM state enum, pixel-beat struct {data, sof, eol, eof}.
- One sub-module: pix_fifo2 (2-entry synchronous FIFO with count output, push/pop same cycle allowed when non-empty).

## Test plan
- Full-speed frame, IMG_W=4, IMG_H=3, RAM preloaded with addr value: m_ready=1 -> 12 beats data 0..11 in consecutive cycles, m_sof on beat 0, m_eol on beats 3,7,11, m_eof on 11, done one cycle later.
- Random backpressure (m_ready 50% random), same config -> identical data/flag sequence, no beat lost or duplicated, m_data stable during stalls, rd_en never overfills FIFO.
- m_ready=0 from the start for 10 cycles -> exactly 2 reads issued (addr 0,1), m_valid=1 holding pixel 0; release -> remaining 10 beats correct.
- start pulsed while busy at beat 5 -> ignored, exactly 12 beats and one done pulse.
- rst_n asserted at beat 6 of a frame -> all outputs at reset values, no done; new start -> frame restarts from address 0 with m_sof.
- Default 256x256 frame, m_ready=1 -> 65536 beats, last rd_addr 65535, m_eof on pixel (255,255), done in cycle n+65539.
